// File: rtl/mem_pkg.sv
// Shared types for the memory stage: FSM encoding and the EX/MEM register layout.
// Pure type package: no latency, no flow control.
package mem_pkg;

    localparam int N_DEFAULT = 64;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} mem_state_t;

    // Fields are sized at the default width; narrower datapaths zero-extend into them.
    typedef struct packed {
        logic                 valid;
        logic                 Branch;
        logic                 MemRead;
        logic                 MemWrite;
        logic                 zero;
        logic [N_DEFAULT-1:0] PCBranch;
        logic [N_DEFAULT-1:0] aluResult;
        logic [N_DEFAULT-1:0] writeData;
    } exmem_t;

endpackage

// File: rtl/flopr_en_clr.sv
// Register with synchronous reset, load enable and synchronous clear; 1-cycle latency.
// Backpressure: holds its value whenever en is low; clr only acts on an enabled edge.
module flopr_en_clr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= clr ? '0 : d;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// LEGv8 MEM stage: EX/MEM register, CBZ resolution, req/ack data-memory access; 1-cycle latency.
// Backpressure: stall_M holds upstream for every REQ cycle until dm_ack or timeout.
module memory_stage
    import mem_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_E,
    input  logic         flush_M,
    input  logic         Branch_E,
    input  logic         MemRead_E,
    input  logic         MemWrite_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic         zero_E,
    output logic [N-1:0] dm_addr,
    output logic [N-1:0] dm_wdata,
    output logic         dm_req,
    output logic         dm_we,
    input  logic         dm_ack,
    input  logic [N-1:0] dm_rdata,
    output logic         stall_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic [N-1:0] aluResult_M,
    output logic [N-1:0] readData_M,
    output logic         valid_M_out,
    output logic         mem_err
);

    localparam int CW = $clog2(TIMEOUT);

    exmem_t          ex_d;
    exmem_t          ex_q;
    mem_state_t      state;
    mem_state_t      state_next;
    logic [CW-1:0]   cnt;
    logic            start_req;
    logic            ack_done;
    logic            timed_out;

    // Flush only kills the valid bit; payload is captured regardless.
    always_comb begin
        ex_d           = '0;
        ex_d.valid     = valid_E & ~flush_M;
        ex_d.Branch    = Branch_E;
        ex_d.MemRead   = MemRead_E;
        ex_d.MemWrite  = MemWrite_E;
        ex_d.zero      = zero_E;
        ex_d.PCBranch  = N_DEFAULT'(PCBranch_E);
        ex_d.aluResult = N_DEFAULT'(aluResult_E);
        ex_d.writeData = N_DEFAULT'(writeData_E);
    end

    flopr_en_clr #(.W($bits(exmem_t))) u_exmem (
        .clk   (clk),
        .reset (reset),
        .en    (~stall_M),
        .clr   (1'b0),
        .d     (ex_d),
        .q     (ex_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stall_M    = 1'b0;
        dm_req     = 1'b0;
        dm_we      = 1'b0;
        start_req  = 1'b0;
        ack_done   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (ex_d.valid && (MemRead_E || MemWrite_E)) begin
                    start_req  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall_M = 1'b1;
                dm_req  = 1'b1;
                dm_we   = ex_q.MemWrite;
                // An ack on the final allowed cycle still completes the access.
                if (dm_ack) begin
                    ack_done   = 1'b1;
                    state_next = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            mem_err    <= 1'b0;
            readData_M <= '0;
        end else begin
            if (start_req) begin
                cnt <= '0;
            end else if (state == REQ) begin
                cnt <= cnt + CW'(1);
            end
            if (ack_done && ex_q.MemRead) begin
                readData_M <= dm_rdata;
            end
            if (timed_out) begin
                mem_err    <= 1'b1;
                readData_M <= '0;
            end
        end
    end

    assign dm_addr     = ex_q.aluResult[N-1:0];
    assign dm_wdata    = ex_q.writeData[N-1:0];
    assign PCBranch_M  = ex_q.PCBranch[N-1:0];
    assign aluResult_M = ex_q.aluResult[N-1:0];
    assign PCSrc_M     = ex_q.valid & ex_q.Branch & ex_q.zero & (state == IDLE);
    assign valid_M_out = ex_q.valid & (state == IDLE);

endmodule

// File: tb/tb_memory_stage.sv
// Directed stimulus for memory_stage; results scoreboarded against hand-computed values.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_E, flush_M, Branch_E, MemRead_E, MemWrite_E, zero_E;
    logic [63:0] PCBranch_E, aluResult_E, writeData_E;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic        dm_req, dm_we, dm_ack;
    logic        stall_M, PCSrc_M, valid_M_out, mem_err;
    logic [63:0] PCBranch_M, aluResult_M, readData_M;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] alu;
        logic [63:0] rdata;
        logic        pcsrc;
        logic [63:0] pcb;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    memory_stage dut (
        .clk         (clk),
        .reset       (reset),
        .valid_E     (valid_E),
        .flush_M     (flush_M),
        .Branch_E    (Branch_E),
        .MemRead_E   (MemRead_E),
        .MemWrite_E  (MemWrite_E),
        .PCBranch_E  (PCBranch_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .zero_E      (zero_E),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .stall_M     (stall_M),
        .PCSrc_M     (PCSrc_M),
        .PCBranch_M  (PCBranch_M),
        .aluResult_M (aluResult_M),
        .readData_M  (readData_M),
        .valid_M_out (valid_M_out),
        .mem_err     (mem_err)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endfunction

    // Monitor: every completed stage result must match the oldest expectation.
    always @(negedge clk) begin
        if (valid_M_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got alu 0x%0h, expected no result", aluResult_M);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_alu",   aluResult_M, e.alu);
                chk("res_rdata", readData_M,  e.rdata);
                chk("res_pcsrc", {63'd0, PCSrc_M}, {63'd0, e.pcsrc});
                chk("res_pcb",   PCBranch_M,  e.pcb);
            end
        end
    end

    task automatic clear_inputs();
        valid_E = 0; flush_M = 0; Branch_E = 0; MemRead_E = 0; MemWrite_E = 0; zero_E = 0;
        PCBranch_E = '0; aluResult_E = '0; writeData_E = '0;
    endtask

    task automatic expect_result(input logic [63:0] alu, rdata, input logic pcsrc, input logic [63:0] pcb);
        exp_t e;
        e.alu = alu; e.rdata = rdata; e.pcsrc = pcsrc; e.pcb = pcb;
        sb.push_back(e);
    endtask

    // Drive one instruction for one capture edge; returns at the following negedge.
    task automatic issue(input logic br, rd, wr, z, fl, input logic [63:0] pcb, alu, wd);
        valid_E = 1; Branch_E = br; MemRead_E = rd; MemWrite_E = wr; zero_E = z; flush_M = fl;
        PCBranch_E = pcb; aluResult_E = alu; writeData_E = wd;
        @(negedge clk);
        clear_inputs();
    endtask

    // Serve an outstanding access, acking in REQ cycle ack_at (0 = never).
    task automatic mem_wait(input string nm, input int ack_at, input logic [63:0] rdata,
                            input logic [63:0] addr, wdata, input logic we, input int exp_stalls);
        int stalls = 0;
        while (stall_M && stalls < 40) begin
            stalls++;
            chk({nm, "_addr"},  dm_addr, addr);
            chk({nm, "_we"},    {63'd0, dm_we}, {63'd0, we});
            chk({nm, "_req"},   {63'd0, dm_req}, 64'd1);
            chk({nm, "_pcsrc"}, {63'd0, PCSrc_M}, 64'd0);
            if (we) chk({nm, "_wdata"}, dm_wdata, wdata);
            if (stalls == ack_at) begin
                dm_ack = 1; dm_rdata = rdata;
            end
            @(negedge clk);
            dm_ack = 0;
        end
        chk({nm, "_stalls"}, 64'(stalls), 64'(exp_stalls));
        chk({nm, "_req_done"}, {63'd0, dm_req}, 64'd0);
        chk({nm, "_we_done"},  {63'd0, dm_we},  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        dm_ack = 0; dm_rdata = '0;
        reset = 1;
        repeat (2) @(negedge clk);
        chk("rst_stall",  {63'd0, stall_M}, 64'd0);
        chk("rst_req",    {63'd0, dm_req}, 64'd0);
        chk("rst_valid",  {63'd0, valid_M_out}, 64'd0);
        chk("rst_err",    {63'd0, mem_err}, 64'd0);
        chk("rst_alu",    aluResult_M, 64'd0);
        chk("rst_rdata",  readData_M, 64'd0);
        chk("rst_pcsrc",  {63'd0, PCSrc_M}, 64'd0);
        reset = 0;
        @(negedge clk);

        // ALU op flows through in one cycle
        expect_result(64'h2A, 64'h0, 1'b0, 64'h0);
        issue(0, 0, 0, 0, 0, 64'h0, 64'h2A, 64'h0);
        chk("alu_stall", {63'd0, stall_M}, 64'd0);
        chk("alu_req",   {63'd0, dm_req}, 64'd0);
        @(negedge clk);

        // LDUR acked in third REQ cycle
        expect_result(64'h100, 64'hDEAD, 1'b0, 64'h0);
        issue(0, 1, 0, 0, 0, 64'h0, 64'h100, 64'h0);
        mem_wait("ld", 3, 64'hDEAD, 64'h100, 64'h0, 1'b0, 3);
        @(negedge clk);

        // STUR acked in first REQ cycle, readData keeps last load
        expect_result(64'h8, 64'hDEAD, 1'b0, 64'h0);
        issue(0, 0, 1, 0, 0, 64'h0, 64'h8, 64'h55);
        mem_wait("st", 1, 64'hBAD0, 64'h8, 64'h55, 1'b1, 1);
        @(negedge clk);

        // CBZ taken: PCSrc for exactly one cycle
        expect_result(64'h0, 64'hDEAD, 1'b1, 64'h40);
        issue(1, 0, 0, 1, 0, 64'h40, 64'h0, 64'h0);
        chk("br_pcb", PCBranch_M, 64'h40);
        @(negedge clk);
        chk("br_pcsrc_drop", {63'd0, PCSrc_M}, 64'd0);

        // Flushed CBZ: payload captured, no branch
        issue(1, 0, 0, 1, 1, 64'h40, 64'h0, 64'h0);
        chk("flush_pcsrc", {63'd0, PCSrc_M}, 64'd0);
        chk("flush_valid", {63'd0, valid_M_out}, 64'd0);
        chk("flush_pcb",   PCBranch_M, 64'h40);
        @(negedge clk);

        // Illegal Branch+LDUR: memory first, branch once IDLE
        expect_result(64'h200, 64'h1234, 1'b1, 64'h80);
        issue(1, 1, 0, 1, 0, 64'h80, 64'h200, 64'h0);
        mem_wait("combo", 2, 64'h1234, 64'h200, 64'h0, 1'b0, 2);
        @(negedge clk);

        // LDUR never acked: timeout after 16 REQ cycles
        expect_result(64'h300, 64'h0, 1'b0, 64'h0);
        issue(0, 1, 0, 0, 0, 64'h0, 64'h300, 64'h0);
        mem_wait("tmo", 0, 64'h0, 64'h300, 64'h0, 1'b0, 16);
        chk("tmo_err", {63'd0, mem_err}, 64'd1);
        @(negedge clk);
        expect_result(64'h7, 64'h0, 1'b0, 64'h0);
        issue(0, 0, 0, 0, 0, 64'h0, 64'h7, 64'h0);
        chk("tmo_err_sticky", {63'd0, mem_err}, 64'd1);
        @(negedge clk);

        // Reset during second REQ cycle; later ack is ignored
        issue(0, 1, 0, 0, 0, 64'h0, 64'h400, 64'h0);
        chk("rreq_stall1", {63'd0, stall_M}, 64'd1);
        @(negedge clk);
        chk("rreq_stall2", {63'd0, stall_M}, 64'd1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rreq_req",   {63'd0, dm_req}, 64'd0);
        chk("rreq_stall", {63'd0, stall_M}, 64'd0);
        chk("rreq_err",   {63'd0, mem_err}, 64'd0);
        dm_ack = 1; dm_rdata = 64'hBEEF;
        @(negedge clk);
        dm_ack = 0;
        chk("rreq_ign_stall", {63'd0, stall_M}, 64'd0);
        chk("rreq_ign_req",   {63'd0, dm_req}, 64'd0);
        chk("rreq_ign_rdata", readData_M, 64'd0);
        @(negedge clk);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
